jpeg_qnr_stage: RTL and testbench
=================================

Name: jpeg_qnr_stage

Overview:
Quantize-and-round stage directly downstream of the zigzag reorder in the jpeg_encoder datapath. It consumes the zigzag-ordered 12-bit signed DCT coefficient stream, one coefficient per beat, 64 per block. Each coefficient is multiplied by a per-position 16-bit reciprocal quantizer value, rounded half away from zero, and saturated to 11-bit signed. The 11-bit result feeds the run-length coder.

Parameters:
DIN_W, 12, input coefficient width (signed, two's complement)
DOUT_W, 11, output coefficient width (signed)
RECIP_W, 16, reciprocal width (unsigned, Q0.16: recip = round(65535/Q))

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous reset, active-high
din  in  DIN_W  zigzag coefficient
din_valid  in  1  din qualifier
din_sob  in  1  start of block; marks coefficient index 0
din_ready  out  1  stage can accept a beat
dout  out  DOUT_W  quantized coefficient
dout_valid  out  1  dout qualifier
dout_sob  out  1  dout is coefficient 0 of its block
dout_eob  out  1  dout is coefficient 63 of its block
dout_ready  in  1  downstream accepts a beat
sat_flag  out  1  dout was saturated (qualified by dout_valid)

Behaviour:
- One clock, synchronous active-high reset on clk.
- Reset clears every pipeline valid bit, dout, dout_sob, dout_eob, sat_flag and the index counter to 0. din_ready becomes 1 in the first cycle after reset. Reset takes effect mid-block: in-flight beats are discarded and the next beat gets index 0 even without din_sob. Reset does not touch the reciprocal table.
- Global advance: adv = !dout_valid | dout_ready; din_ready = adv. All three stages shift together when adv=1 and hold when adv=0. A beat transfers only when valid & ready are both 1.
- Latency: a beat accepted in cycle N presents dout_valid in cycle N+3 when unstalled. Throughput is 1 beat/cycle. Bubbles propagate as invalid slots.
- Index counter (6 bits):
  - Accepted beat with din_sob=1: beat index = 0, counter becomes 1.
  - Accepted beat otherwise: beat index = counter, counter increments mod 64 (63 wraps to 0).
  - din_sob on a beat mid-block resynchronises to 0 with no error.
- S1: register din, index and sob; synchronous table read recip[index].
- S2: sign = din[DIN_W-1]; mag = |din| (13-bit unsigned, so -2048 gives 2048); prod = mag*recip (29-bit unsigned).
- S3: q = (prod + 2^15) >> 16. If sign=0 and q > 1023, output 1023. If sign=1 and q > 1024, output -1024. Otherwise output ±q. sat_flag = 1 when clipped. dout_eob = (index == 63).
- Negative zero (q=0, sign=1) outputs 0.

Optional Feature:
JPEG_QNR_QT_LOAD_EN.
- Defined: adds ports qt_we (in, 1), qt_addr (in, 6) and qt_data (in, RECIP_W), giving a runtime-writable table. A write lands on the clock edge. A read of the same address in the same cycle returns the old value. Writes are legal at any time and affect beats read afterwards.
- Not defined: ports are absent and the table is the constant JPEG_QNR_DEFAULT_RECIP (standard luminance table, zigzag order, quality 50).
- Reset value in both cases is the default table.

Decomposition:
- Package jpeg_qnr_pkg: DIN_W, DOUT_W and RECIP_W defaults; JPEG_QNR_ROUND = 2^15; DOUT_MAX = 1023; DOUT_MIN = -1024; JPEG_QNR_DEFAULT_RECIP[64] constant array; coef_idx_t (6-bit) typedef.
- One sub-module, jpeg_qnr_recip_tbl: 64xRECIP_W synchronous-read table with optional write port.

Test Plan:
- Table entry 5 = 4096 (Q=16); block with din=100 at index 5 -> dout=6, sat_flag=0, 3-cycle latency.
- din=-24 at recip 4096 -> dout=-2 (−1.5 rounds away from zero); din=8 -> dout=1 (0.5 rounds up).
- recip=65535: din=2047 -> dout=1023, sat_flag=1; din=-2048 -> dout=-1024, sat_flag=1; din=-1024 -> dout=-1024, sat_flag=0.
- 130 back-to-back beats, first with din_sob -> dout_sob on beats 0 and 64, dout_eob on beats 63 and 127, counter wraps correctly.
- dout_ready held low for 5 cycles mid-stream with din_valid=1 -> no loss or duplication, din_ready=0 while the stage is full, order preserved.
- rst asserted at beat 30, then 64 beats sent without din_sob -> first post-reset beat is index 0, no stale dout_valid.

Source files
------------

// File: rtl/jpeg_qnr_pkg.sv
// Shared widths, rounding/saturation constants and the default reciprocal
// quantizer table for the JPEG quantize-and-round stage.
package jpeg_qnr_pkg;

  localparam int DIN_W          = 12;
  localparam int DOUT_W         = 11;
  localparam int RECIP_W        = 16;
  localparam int PROD_W         = DIN_W + 1 + RECIP_W;
  localparam int Q_W            = PROD_W - 16;
  localparam int JPEG_QNR_ROUND = 32768;
  localparam int DOUT_MAX       = 1023;
  localparam int DOUT_MIN       = -1024;

  typedef logic [5:0] coef_idx_t;

  // round(65535/Q) of the quality-50 luminance table, listed in zigzag order
  localparam logic [RECIP_W-1:0] JPEG_QNR_DEFAULT_RECIP [64] = '{
    16'd4096, 16'd5958, 16'd5461, 16'd4681, 16'd5461, 16'd6554, 16'd4096, 16'd4681,
    16'd5041, 16'd4681, 16'd3641, 16'd3855, 16'd4096, 16'd3449, 16'd2731, 16'd1638,
    16'd2521, 16'd2731, 16'd2979, 16'd2979, 16'd2731, 16'd1337, 16'd1872, 16'd1771,
    16'd2260, 16'd1638, 16'd1130, 16'd1285, 16'd1074, 16'd1092, 16'd1150, 16'd1285,
    16'd1170, 16'd1192, 16'd1024, 16'd910,  16'd712,  16'd840,  16'd1024, 16'd964,
    16'd753,  16'd950,  16'd1192, 16'd1170, 16'd819,  16'd601,  16'd809,  16'd753,
    16'd690,  16'd669,  16'd636,  16'd630,  16'd636,  16'd1057, 16'd851,  16'd580,
    16'd542,  16'd585,  16'd655,  16'd546,  16'd712,  16'd649,  16'd636,  16'd662
  };

endpackage

// File: rtl/jpeg_qnr_recip_tbl.sv
// 64-entry reciprocal quantizer table with registered read.
// JPEG_QNR_QT_LOAD_EN adds a write port; otherwise the table is the default constant.
module jpeg_qnr_recip_tbl
  import jpeg_qnr_pkg::*;
(
  input  logic               clk,
  input  logic               re,
  input  coef_idx_t          raddr,
  output logic [RECIP_W-1:0] rdata
`ifdef JPEG_QNR_QT_LOAD_EN
  ,
  input  logic               we,
  input  coef_idx_t          waddr,
  input  logic [RECIP_W-1:0] wdata
`endif
);

`ifdef JPEG_QNR_QT_LOAD_EN
  // Power-up contents are the default table; reset never rewrites them.
  logic [RECIP_W-1:0] mem [64] = JPEG_QNR_DEFAULT_RECIP;

  // Write lands on the edge; a same-cycle read of that address sees the old value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end
`else
  // Constant table lookup, held while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= JPEG_QNR_DEFAULT_RECIP[raddr];
    end
  end
`endif

endmodule

// File: rtl/jpeg_qnr_stage.sv
// Three-stage quantize / round-half-away / saturate pipeline for zigzag DCT coefficients.
// Optional runtime table loading is enabled with JPEG_QNR_QT_LOAD_EN.
module jpeg_qnr_stage
  import jpeg_qnr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  input  logic              din_sob,
  output logic              din_ready,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_sob,
  output logic              dout_eob,
  input  logic              dout_ready,
  output logic              sat_flag
`ifdef JPEG_QNR_QT_LOAD_EN
  ,
  input  logic               qt_we,
  input  coef_idx_t          qt_addr,
  input  logic [RECIP_W-1:0] qt_data
`endif
);

  logic               adv;
  logic               fire;
  coef_idx_t          cnt;
  coef_idx_t          idx_in;
  logic               v1;
  logic [DIN_W-1:0]   din1;
  coef_idx_t          idx1;
  logic [RECIP_W-1:0] recip1;
  logic               v2;
  logic               sign2;
  coef_idx_t          idx2;
  logic [PROD_W-1:0]  prod2;
  logic [DIN_W:0]     mag;
  logic [Q_W-1:0]     q;
  logic [DOUT_W-1:0]  dout_n;
  logic               sat_n;

  // Handshake and beat index; din_sob forces index 0 wherever it appears.
  always_comb begin
    adv       = !dout_valid || dout_ready;
    din_ready = adv;
    fire      = din_valid && adv;
    idx_in    = din_sob ? 6'd0 : cnt;
  end

  jpeg_qnr_recip_tbl u_tbl (
    .clk   (clk),
    .re    (adv),
    .raddr (idx_in),
    .rdata (recip1)
`ifdef JPEG_QNR_QT_LOAD_EN
    ,
    .we    (qt_we),
    .waddr (qt_addr),
    .wdata (qt_data)
`endif
  );

  // Magnitude is one bit wider than din so -2048 maps to +2048.
  always_comb begin
    mag = din1[DIN_W-1] ? ((DIN_W+1)'(0) - {din1[DIN_W-1], din1}) : {1'b0, din1};
  end

  // Round the magnitude, then clip asymmetrically to the signed output range.
  always_comb begin
    q      = Q_W'((prod2 + PROD_W'(JPEG_QNR_ROUND)) >> 16);
    sat_n  = 1'b0;
    dout_n = q[DOUT_W-1:0];
    if (!sign2 && (q > Q_W'(DOUT_MAX))) begin
      dout_n = DOUT_W'(DOUT_MAX);
      sat_n  = 1'b1;
    end else if (sign2 && (q > Q_W'(-DOUT_MIN))) begin
      dout_n = DOUT_W'(DOUT_MIN);
      sat_n  = 1'b1;
    end else if (sign2) begin
      dout_n = DOUT_W'(0) - q[DOUT_W-1:0];
    end else begin
      dout_n = q[DOUT_W-1:0];
    end
  end

  // All stages shift together on adv; reset drops in-flight beats and restarts the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 6'd0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_sob   <= 1'b0;
      dout_eob   <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      if (fire) begin
        cnt <= idx_in + 6'd1;
      end
      if (adv) begin
        v1         <= din_valid;
        din1       <= din;
        idx1       <= idx_in;
        v2         <= v1;
        sign2      <= din1[DIN_W-1];
        prod2      <= PROD_W'(mag) * PROD_W'(recip1);
        idx2       <= idx1;
        dout_valid <= v2;
        dout       <= dout_n;
        dout_sob   <= v2 && (idx2 == 6'd0);
        dout_eob   <= v2 && (idx2 == 6'd63);
        sat_flag   <= v2 && sat_n;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_qnr_stage.sv
// Randomized self-checking bench for jpeg_qnr_stage against a queue-based arithmetic model.
module tb_jpeg_qnr_stage;

  // Quality-50 luminance quantizers in zigzag order; reciprocals are derived here.
  localparam int QZ [64] = '{
    16, 11, 12, 14, 12, 10, 16, 14, 13, 14, 18, 17, 16, 19, 24, 40,
    26, 24, 22, 22, 24, 49, 35, 37, 29, 40, 58, 51, 61, 60, 57, 51,
    56, 55, 64, 72, 92, 78, 64, 68, 87, 69, 55, 56, 80, 109, 81, 87,
    95, 98, 103, 104, 103, 62, 77, 113, 121, 112, 100, 120, 92, 101, 103, 99};

  typedef struct { int d; bit s; bit e; bit sat; int cyc; bit lat; } exp_t;
  typedef struct { int d; bit s; bit e; bit sat; } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] din;
  logic        din_valid, din_sob, din_ready;
  logic [10:0] dout;
  logic        dout_valid, dout_sob, dout_eob, dout_ready, sat_flag;
`ifdef JPEG_QNR_QT_LOAD_EN
  logic        qt_we;
  logic [5:0]  qt_addr;
  logic [15:0] qt_data;
  bit          wr_rand = 1'b0;
`endif

  int   n_chk = 0, n_fail = 0, cyc = 0, mcnt = 0;
  bit   prev_rst = 1'b0, lat_chk = 1'b0;
  int   shadow [64];
  exp_t exp_q [$];
  obs_t obs [$];
  int   stim [$];
  bit   stim_sob [$];

  jpeg_qnr_stage dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_sob    (din_sob),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_sob   (dout_sob),
    .dout_eob   (dout_eob),
    .dout_ready (dout_ready),
    .sat_flag   (sat_flag)
`ifdef JPEG_QNR_QT_LOAD_EN
    ,
    .qt_we      (qt_we),
    .qt_addr    (qt_addr),
    .qt_data    (qt_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int recip_of(input int qv);
    return (2 * 65535 + qv) / (2 * qv);
  endfunction

  function automatic void quant(input int x, input int r, output int y, output bit s);
    longint m, qq;
    m  = (x < 0) ? -x : x;
    qq = (m * r + 32768) / 65536;
    s  = 1'b0;
    if (x >= 0 && qq > 1023) begin
      y = 1023; s = 1'b1;
    end else if (x < 0 && qq > 1024) begin
      y = -1024; s = 1'b1;
    end else begin
      y = (x < 0) ? -int'(qq) : int'(qq);
    end
  endfunction

  // Monitor: mid-cycle, after the driver has settled this cycle's inputs.
  always @(negedge clk) begin
    exp_t e;
    int   idx, x, y;
    bit   s;
    #2;
    cyc++;
    if (rst) begin
      exp_q.delete();
      mcnt     = 0;
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        chk("post_reset_dout_valid", dout_valid, 0);
        chk("post_reset_din_ready", din_ready, 1);
        chk("post_reset_dout", dout, 0);
        chk("post_reset_sat", sat_flag, 0);
      end
      prev_rst = 1'b0;
      chk("din_ready_rule", din_ready, int'(!dout_valid || dout_ready));
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dout", $signed(dout), e.d);
          chk("dout_sob", dout_sob, e.s);
          chk("dout_eob", dout_eob, e.e);
          chk("sat_flag", sat_flag, e.sat);
          if (e.lat) chk("latency", cyc - e.cyc, 3);
          obs.push_back('{$signed(dout), dout_sob, dout_eob, sat_flag});
        end
      end
      if (din_valid && din_ready) begin
        idx  = din_sob ? 0 : mcnt;
        mcnt = (idx + 1) % 64;
        x    = $signed(din);
        quant(x, shadow[idx], y, s);
        exp_q.push_back('{y, idx == 0, idx == 63, s, cyc, lat_chk});
      end
`ifdef JPEG_QNR_QT_LOAD_EN
      if (qt_we) shadow[qt_addr] = qt_data;
`endif
    end
  end

  task automatic run_stream(input int vprob, input int rprob, input int stall_at, input int stall_len);
    int k = 0, g = 0;
    while (k < stim.size() && g < 4000) begin
      @(negedge clk);
      din_valid  = ($urandom_range(99) < vprob);
      din        = 12'(stim[k]);
      din_sob    = stim_sob[k];
      dout_ready = ($urandom_range(99) < rprob) && !(g >= stall_at && g < stall_at + stall_len);
`ifdef JPEG_QNR_QT_LOAD_EN
      qt_we   = wr_rand && ($urandom_range(19) == 0);
      qt_addr = 6'($urandom_range(63));
      qt_data = 16'($urandom);
`endif
      #1;
      if (g == stall_at + stall_len - 1) chk("stall_din_ready", din_ready, 0);
      if (din_valid && din_ready) k++;
      g++;
    end
    chk("stream_complete", k, stim.size());
    @(negedge clk);
    din_valid = 1'b0;
    din_sob   = 1'b0;
`ifdef JPEG_QNR_QT_LOAD_EN
    qt_we = 1'b0;
`endif
    stim.delete();
    stim_sob.delete();
  endtask

  task automatic drain();
    int g = 0;
    dout_ready = 1'b1;
    while (exp_q.size() != 0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

`ifdef JPEG_QNR_QT_LOAD_EN
  task automatic qt_write(input int a, input int d);
    @(negedge clk);
    qt_we = 1'b1; qt_addr = 6'(a); qt_data = 16'(d);
    @(negedge clk);
    qt_we = 1'b0;
  endtask
`endif

  initial begin
    int y;
    bit s;
    for (int i = 0; i < 64; i++) shadow[i] = recip_of(QZ[i]);
    rst = 1'b1; din = '0; din_valid = 1'b0; din_sob = 1'b0; dout_ready = 1'b1;
`ifdef JPEG_QNR_QT_LOAD_EN
    qt_we = 1'b0; qt_addr = '0; qt_data = '0;
`endif

    // Hand-computed anchors for the model itself.
    chk("model_recip_q16", recip_of(16), 4096);
    chk("model_recip_q10", recip_of(10), 6554);
    quant(100, 4096, y, s);    chk("model_100", y, 6);
    quant(-24, 4096, y, s);    chk("model_m24", y, -2);
    quant(8, 4096, y, s);      chk("model_8", y, 1);
    quant(-1, 4096, y, s);     chk("model_negzero", y, 0);
    quant(2047, 65535, y, s);  chk("model_2047", y, 1023);   chk("model_2047_sat", s, 1);
    quant(-2048, 65535, y, s); chk("model_m2048", y, -1024); chk("model_m2048_sat", s, 1);
    quant(-1024, 65535, y, s); chk("model_m1024", y, -1024); chk("model_m1024_sat", s, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;

`ifdef JPEG_QNR_QT_LOAD_EN
    qt_write(1, 65535); qt_write(2, 65535); qt_write(3, 65535); qt_write(5, 4096);
`endif
    // Directed block, unstalled, with latency checking.
    lat_chk = 1'b1;
    obs.delete();
    for (int i = 0; i < 64; i++) begin
      stim.push_back(int'($urandom_range(200)) - 100);
      stim_sob.push_back(i == 0);
    end
    stim[0] = -24; stim[6] = 100; stim[12] = 8;
`ifdef JPEG_QNR_QT_LOAD_EN
    stim[1] = 2047; stim[2] = -2048; stim[3] = -1024; stim[5] = 100;
`endif
    run_stream(100, 100, -1, 0);
    drain();
    chk("blk_count", obs.size(), 64);
    chk("blk_idx0", obs[0].d, -2);
    chk("blk_idx6", obs[6].d, 6);
    chk("blk_idx6_sat", obs[6].sat, 0);
    chk("blk_idx12", obs[12].d, 1);
`ifdef JPEG_QNR_QT_LOAD_EN
    chk("blk_idx1", obs[1].d, 1023);   chk("blk_idx1_sat", obs[1].sat, 1);
    chk("blk_idx2", obs[2].d, -1024);  chk("blk_idx2_sat", obs[2].sat, 1);
    chk("blk_idx3", obs[3].d, -1024);  chk("blk_idx3_sat", obs[3].sat, 0);
    chk("blk_idx5", obs[5].d, 6);
`endif

    // 130 back-to-back beats: index wraps without a second din_sob.
    obs.delete();
    for (int i = 0; i < 130; i++) begin
      stim.push_back(int'($urandom_range(4095)) - 2048);
      stim_sob.push_back(i == 0);
    end
    run_stream(100, 100, -1, 0);
    drain();
    chk("wrap_count", obs.size(), 130);
    chk("wrap_sob0", obs[0].s, 1);
    chk("wrap_sob1", obs[1].s, 0);
    chk("wrap_sob64", obs[64].s, 1);
    chk("wrap_eob63", obs[63].e, 1);
    chk("wrap_eob127", obs[127].e, 1);
    chk("wrap_eob128", obs[128].e, 0);

    // Five-cycle downstream stall with continuous input.
    lat_chk = 1'b0;
    obs.delete();
    for (int i = 0; i < 40; i++) begin
      stim.push_back(int'($urandom_range(4095)) - 2048);
      stim_sob.push_back(i == 0);
    end
    run_stream(100, 100, 10, 5);
    drain();
    chk("stall_count", obs.size(), 40);

    // Random valid/ready/sob traffic.
`ifdef JPEG_QNR_QT_LOAD_EN
    wr_rand = 1'b1;
`endif
    for (int i = 0; i < 300; i++) begin
      stim.push_back(int'($urandom_range(4095)) - 2048);
      stim_sob.push_back($urandom_range(39) == 0);
    end
    run_stream(70, 70, -1, 0);
    drain();
`ifdef JPEG_QNR_QT_LOAD_EN
    wr_rand = 1'b0;
`endif

    // Reset in the middle of a block, then a block sent without din_sob.
    for (int i = 0; i < 30; i++) begin
      stim.push_back(int'($urandom_range(4095)) - 2048);
      stim_sob.push_back(i == 0);
    end
    run_stream(100, 100, -1, 0);
    @(negedge clk);
    rst = 1'b1; din_valid = 1'b1; din = 12'd77; dout_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; din_valid = 1'b0;
    obs.delete();
    for (int i = 0; i < 64; i++) begin
      stim.push_back(int'($urandom_range(4095)) - 2048);
      stim_sob.push_back(1'b0);
    end
    run_stream(100, 100, -1, 0);
    drain();
    chk("rst_count", obs.size(), 64);
    chk("rst_first_sob", obs[0].s, 1);
    chk("rst_eob63", obs[63].e, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
